// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM encoding and
// opcode classification helper.
package alu_pkg;

    localparam int ALU_CTRL_W = 5;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL    = 5'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT    = 5'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU   = 5'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR    = 5'd5;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR     = 5'd8;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND    = 5'd9;
    localparam logic [ALU_CTRL_W-1:0] ALU_LUI    = 5'd10;
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL    = 5'd11;
    localparam logic [ALU_CTRL_W-1:0] ALU_MULH   = 5'd12;
    localparam logic [ALU_CTRL_W-1:0] ALU_MULHSU = 5'd13;
    localparam logic [ALU_CTRL_W-1:0] ALU_MULHU  = 5'd14;
    localparam logic [ALU_CTRL_W-1:0] ALU_DIV    = 5'd15;
    localparam logic [ALU_CTRL_W-1:0] ALU_DIVU   = 5'd16;
    localparam logic [ALU_CTRL_W-1:0] ALU_REM    = 5'd17;
    localparam logic [ALU_CTRL_W-1:0] ALU_REMU   = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // True for the opcodes handled by the iterative multiply/divide unit.
    function automatic logic is_muldiv(input logic [ALU_CTRL_W-1:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/response bus of the iterative ALU.
// Handshake: a request transfers on a rising clock edge where req_valid &&
// req_ready && !flush; a response transfers on an edge where resp_valid &&
// resp_ready. alu_out is stable while resp_valid && !resp_ready.
interface alu_if #(parameter int XLEN = 32);
    import alu_pkg::*;

    logic                  flush;
    logic                  req_valid;
    logic                  req_ready;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [XLEN-1:0]       data_x;
    logic [XLEN-1:0]       data_y;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [XLEN-1:0]       alu_out;

    modport master (
        output flush, req_valid, alu_ctrl, data_x, data_y, resp_ready,
        input  req_ready, resp_valid, alu_out
    );

    modport slave (
        input  flush, req_valid, alu_ctrl, data_x, data_y, resp_ready,
        output req_ready, resp_valid, alu_out
    );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative radix-2 multiply/divide datapath. Operates on magnitudes and
// applies the sign correction on the final step. done_o marks the cycle in
// which result_o is valid (last iteration, combinational).
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  start_i,
    input  logic [ALU_CTRL_W-1:0] op_i,
    input  logic [XLEN-1:0]       x_i,
    input  logic [XLEN-1:0]       y_i,
    output logic                  done_o,
    output logic [XLEN-1:0]       result_o
);

    localparam int CNT_W = $clog2(XLEN);

    logic                  busy_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ALU_CTRL_W-1:0] op_q;
    logic                  neg_q;
    logic                  divzero_q;
    logic [XLEN-1:0]       x_raw_q;
    // Multiplicand (mul) or divisor (div) magnitude.
    logic [XLEN-1:0]       opa_q;
    // Mul: {partial product high, remaining multiplier}. Div: {remainder, quotient}.
    logic [2*XLEN-1:0]     acc_q;
    logic [2*XLEN-1:0]     acc_d;

    logic                  x_signed;
    logic                  y_signed;
    logic                  x_neg;
    logic                  y_neg;
    logic [XLEN-1:0]       x_mag;
    logic [XLEN-1:0]       y_mag;
    logic                  op_is_mul;
    logic [XLEN:0]         mul_sum;
    logic [XLEN:0]         div_shift;
    logic [XLEN:0]         div_diff;
    logic [2*XLEN-1:0]     prod_fix;
    logic [XLEN-1:0]       quo_fix;
    logic [XLEN-1:0]       rem_fix;

    // Operand sign handling at start.
    always_comb begin
        x_signed = (op_i == ALU_MULH) || (op_i == ALU_MULHSU) ||
                   (op_i == ALU_DIV)  || (op_i == ALU_REM);
        y_signed = (op_i == ALU_MULH) || (op_i == ALU_DIV) || (op_i == ALU_REM);
        x_neg    = x_signed && x_i[XLEN-1];
        y_neg    = y_signed && y_i[XLEN-1];
        x_mag    = x_neg ? (~x_i + 1'b1) : x_i;
        y_mag    = y_neg ? (~y_i + 1'b1) : y_i;
    end

    // One radix-2 step: shift-add for mul, restoring subtract for div.
    always_comb begin
        op_is_mul = (op_q <= ALU_MULHU);
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opa_q : {XLEN{1'b0}})};
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opa_q};
        if (op_is_mul) begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end else if (div_diff[XLEN]) begin
            acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // Sign fix-up and special cases applied to the final step's value.
    always_comb begin
        prod_fix = neg_q ? (~acc_d + 1'b1) : acc_d;
        quo_fix  = neg_q ? (~acc_d[XLEN-1:0] + 1'b1) : acc_d[XLEN-1:0];
        rem_fix  = neg_q ? (~acc_d[2*XLEN-1:XLEN] + 1'b1) : acc_d[2*XLEN-1:XLEN];
        result_o = '0;
        case (op_q)
            ALU_MUL:                         result_o = prod_fix[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:               result_o = divzero_q ? {XLEN{1'b1}} : quo_fix;
            ALU_REM, ALU_REMU:               result_o = divzero_q ? x_raw_q : rem_fix;
            default:                         result_o = '0;
        endcase
    end

    assign done_o = busy_q && (cnt_q == '0);

    // Operand latch on start, then XLEN iterations counted down to zero.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q    <= 1'b1;
            cnt_q     <= CNT_W'(XLEN - 1);
            op_q      <= op_i;
            x_raw_q   <= x_i;
            divzero_q <= (y_i == '0);
            if (op_i <= ALU_MULHU) begin
                opa_q <= x_mag;
                acc_q <= {{XLEN{1'b0}}, y_mag};
                neg_q <= x_neg ^ y_neg;
            end else begin
                opa_q <= y_mag;
                acc_q <= {{XLEN{1'b0}}, x_mag};
                neg_q <= (op_i == ALU_REM) ? x_neg : (x_neg ^ y_neg);
            end
        end else if (busy_q) begin
            acc_q <= acc_d;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_iter.sv
// EX-stage ALU: single-cycle base RV32I ops and iterative RV32M mul/div
// behind a valid/ready request/response handshake.
module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_if.slave       bus,
    output alu_state_e state_o
);

    localparam int SHAMT_W = $clog2(XLEN);

    alu_state_e         state_q;
    logic               resp_valid_q;
    logic [XLEN-1:0]    alu_out_q;
    logic [XLEN-1:0]    base_res;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               md_start;
    logic               md_done;
    logic [XLEN-1:0]    md_result;

    assign bus.req_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.resp_ready);
    assign accept         = bus.req_valid && bus.req_ready && !bus.flush;
    assign md_start       = accept && is_muldiv(bus.alu_ctrl);
    assign shamt          = bus.data_y[SHAMT_W-1:0];
    assign bus.resp_valid = resp_valid_q;
    assign bus.alu_out    = alu_out_q;
    assign state_o        = state_q;

    // Combinational base ALU; mul/div and undefined opcodes give 0 here.
    always_comb begin
        base_res = '0;
        case (bus.alu_ctrl)
            ALU_ADD:  base_res = bus.data_x + bus.data_y;
            ALU_SUB:  base_res = bus.data_x - bus.data_y;
            ALU_SLL:  base_res = bus.data_x << shamt;
            ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(bus.data_x) < $signed(bus.data_y))};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (bus.data_x < bus.data_y)};
            ALU_XOR:  base_res = bus.data_x ^ bus.data_y;
            ALU_SRL:  base_res = bus.data_x >> shamt;
            ALU_SRA:  base_res = $signed(bus.data_x) >>> shamt;
            ALU_OR:   base_res = bus.data_x | bus.data_y;
            ALU_AND:  base_res = bus.data_x & bus.data_y;
            ALU_LUI:  base_res = bus.data_y;
            default:  base_res = '0;
        endcase
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (bus.flush),
        .start_i  (md_start),
        .op_i     (bus.alu_ctrl),
        .x_i      (bus.data_x),
        .y_i      (bus.data_y),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // Control FSM with registered response; flush beats resp_ready and accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            alu_out_q    <= '0;
        end else if (bus.flush) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (is_muldiv(bus.alu_ctrl)) begin
                            state_q      <= ST_BUSY;
                            resp_valid_q <= 1'b0;
                        end else begin
                            state_q      <= ST_DONE;
                            resp_valid_q <= 1'b1;
                            alu_out_q    <= base_res;
                        end
                    end else if ((state_q == ST_IDLE) || bus.resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state_q      <= ST_DONE;
                        resp_valid_q <= 1'b1;
                        alu_out_q    <= md_result;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: directed corner cases plus random ops with random
// response back-pressure, checked through an expected-result scoreboard.
module tb_alu_iter;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    alu_state_e state;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         rand_rr = 1'b0;

    logic [XLEN-1:0] exp_q[$];
    int              due_q[$];
    logic [XLEN-1:0] cur_exp;
    int              cur_due;
    bit              seen = 1'b0;

    alu_if #(.XLEN(XLEN)) bus();

    alu_iter #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .state_o (state)
    );

    // Clock and cycle count.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model from the instruction set definitions.
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        longint    sx = longint'($signed(x));
        longint    sy = longint'($signed(y));
        longint    ux = longint'({32'd0, x});
        longint    uy = longint'({32'd0, y});
        logic [63:0] p;
        case (op)
            ALU_ADD:  return x + y;
            ALU_SUB:  return x - y;
            ALU_SLL:  return x << y[4:0];
            ALU_SLT:  return (sx < sy) ? 32'd1 : 32'd0;
            ALU_SLTU: return (ux < uy) ? 32'd1 : 32'd0;
            ALU_XOR:  return x ^ y;
            ALU_SRL:  return x >> y[4:0];
            ALU_SRA:  return 32'(sx >>> y[4:0]);
            ALU_OR:   return x | y;
            ALU_AND:  return x & y;
            ALU_LUI:  return y;
            ALU_MUL:    begin p = 64'(sx * sy); return p[31:0]; end
            ALU_MULH:   begin p = 64'(sx * sy); return p[63:32]; end
            ALU_MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
            ALU_MULHU:  begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
            ALU_DIV: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return 32'(sx / sy);
            end
            ALU_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            ALU_REM: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sx % sy);
            end
            ALU_REMU: return (y == 0) ? x : x % y;
            default:  return 32'd0;
        endcase
    endfunction

    // Monitor: latency on first sight of a response, value every valid cycle.
    always @(negedge clk) begin
        if (!rst && bus.resp_valid) begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got alu_out %h with no pending op (cycle %0d)", bus.alu_out, cyc);
                end else begin
                    cur_exp = exp_q.pop_front();
                    cur_due = due_q.pop_front();
                    seen    = 1'b1;
                    check32("latency", 32'(cyc), 32'(cur_due));
                end
            end
            if (seen) begin
                check32("alu_out", bus.alu_out, cur_exp);
                if (!bus.resp_ready) check32("req_ready_hold", 32'(bus.req_ready), 32'd0);
                else seen = 1'b0;
            end
        end
    end

    // Random back-pressure on the response side.
    always @(posedge clk) begin
        if (rand_rr) begin
            #1;
            bus.resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Driver: call at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y, input bit track);
        int waited = 0;
        bit got = 1'b0;
        bus.req_valid = 1'b1;
        bus.alu_ctrl  = op;
        bus.data_x    = x;
        bus.data_y    = y;
        while (!got && waited < 400) begin
            @(negedge clk);
            if (bus.req_ready && !bus.flush) begin
                got = 1'b1;
                if (track) begin
                    exp_q.push_back(model(op, x, y));
                    due_q.push_back(cyc + (is_muldiv(op) ? XLEN + 1 : 1));
                end
            end else begin
                waited++;
            end
        end
        if (!got) check32("accept_timeout", 32'(op), 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.data_x    = $urandom;
        bus.data_y    = $urandom;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || seen) && w < 300) begin
            @(negedge clk);
            w++;
        end
        check32("drain", 32'(exp_q.size()) + 32'(seen), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int vcount;
        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.alu_ctrl   = '0;
        bus.data_x     = '0;
        bus.data_y     = '0;
        bus.resp_ready = 1'b1;

        // Reset.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check32("rst_state", 32'(state), 32'(ST_IDLE));
        check32("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check32("rst_alu_out", bus.alu_out, 32'd0);
        check32("rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Base ops, back to back.
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(ALU_SRA, 32'h8000_0000, 32'h0000_0024, 1'b1);
        issue(ALU_SLL, 32'h0000_0003, 32'd33, 1'b1);
        issue(ALU_SLT, 32'hFFFF_FFFE, 32'd1, 1'b1);
        issue(ALU_SLTU, 32'hFFFF_FFFE, 32'd1, 1'b1);
        issue(ALU_LUI, 32'h1234_5678, 32'hABCD_E000, 1'b1);
        issue(5'd25, 32'h1234_5678, 32'h1, 1'b1);
        // Mul/div corners.
        issue(ALU_MULH, 32'hFFFF_FFFE, 32'd3, 1'b1);
        issue(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(ALU_MUL, 32'hFFFF_FFFD, 32'd7, 1'b1);
        issue(ALU_DIV, 32'd7, 32'd0, 1'b1);
        issue(ALU_REMU, 32'd7, 32'd0, 1'b1);
        issue(ALU_REM, 32'hFFFF_FFF9, 32'd0, 1'b1);
        issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(ALU_REM, 32'hFFFF_FFF9, 32'd2, 1'b1);
        drain();

        // Back-pressure: DIV -7/2 held for 5 cycles with an ADD waiting.
        bus.resp_ready = 1'b0;
        issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        fork
            issue(ALU_ADD, 32'd10, 32'd20, 1'b1);
        join_none
        vcount = 0;
        while (!bus.resp_valid && vcount < 60) begin
            @(negedge clk);
            vcount++;
        end
        check32("hold_valid_seen", 32'(bus.resp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            check32("hold_state", 32'(state), 32'(ST_DONE));
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        wait fork;
        drain();

        // Flush during DIVU at BUSY cycle 10.
        issue(ALU_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check32("flush_state", 32'(state), 32'(ST_IDLE));
        check32("flush_req_ready", 32'(bus.req_ready), 32'd1);
        vcount = 0;
        repeat (40) begin
            if (bus.resp_valid) vcount++;
            @(negedge clk);
        end
        check32("flush_no_valid", 32'(vcount), 32'd0);
        @(posedge clk);
        #1;
        issue(ALU_ADD, 32'd2, 32'd3, 1'b1);
        drain();

        // Reset in the middle of a MUL clears alu_out.
        issue(ALU_MUL, 32'd1234, 32'd5678, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check32("midrst_alu_out", bus.alu_out, 32'd0);
        check32("midrst_state", 32'(state), 32'(ST_IDLE));
        check32("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #1;

        // Random ops under random back-pressure.
        rand_rr = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [4:0] op;
            op = (i % 3 == 0) ? 5'($urandom_range(ALU_MUL, ALU_REMU)) : 5'($urandom_range(0, 31));
            issue(op, rand_operand(), rand_operand(), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rr = 1'b0;
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
